// File: rtl/adder_share_ctrl.sv
// Round-robin controller time-sharing one ripple-carry adder among NUM_REQ requesters.
// Registers the winner's sum/carry and holds it under a valid/ack handshake with an ack timeout.
module adder_share_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 3,
  parameter int ACK_TIMEOUT = 1000,
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*WIDTH-1:0] b_flat,
  input  logic [NUM_REQ-1:0]       cin,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  input  logic                     rsp_ack,
  output logic                     busy,
  output logic [7:0]               timeout_cnt,
  output logic [1:0]               o_dbg_state,
  output logic [IDW-1:0]           o_dbg_ptr
);

  localparam int TW = $clog2(ACK_TIMEOUT);

  // Handshake: a result is transferred on any rising edge where rsp_valid=1 and
  // rsp_ack=1; rsp_ack with rsp_valid=0 has no effect. If no transfer happens within
  // ACK_TIMEOUT valid cycles the result is dropped and timeout_cnt bumps.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_win_id;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [TW-1:0]      r_timer;
  logic [7:0]         r_timeout_cnt;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [IDW-1:0]     w_idx;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;
  logic               w_cin_sel;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;
  logic [IDW-1:0]     w_ptr_next;
  logic               w_timer_done;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_a_sel   = '0;
    w_b_sel   = '0;
    w_cin_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a_sel   = a_flat[i*WIDTH +: WIDTH];
        w_b_sel   = b_flat[i*WIDTH +: WIDTH];
        w_cin_sel = cin[i];
      end
    end
  end

  // The shared ripple-carry adder, fed only from the latched operands.
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = r_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]     = r_a[i] ^ r_b[i] ^ w_carry[i];
      w_carry[i+1] = (r_a[i] & r_b[i]) | (w_carry[i] & (r_a[i] ^ r_b[i]));
    end
  end

  assign w_ptr_next   = (r_win_id == IDW'(NUM_REQ - 1)) ? '0 : r_win_id + IDW'(1);
  assign w_timer_done = (r_timer == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ack || w_timer_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_win_id      <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_cin         <= 1'b0;
      r_grant       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_sum         <= '0;
      r_cout        <= 1'b0;
      r_timer       <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_win_id <= w_win;
            r_a      <= w_a_sel;
            r_b      <= w_b_sel;
            r_cin    <= w_cin_sel;
            r_grant  <= NUM_REQ'(1) << w_win;
          end
        end
        EXEC: begin
          r_sum       <= w_sum;
          r_cout      <= w_carry[WIDTH];
          r_rsp_id    <= r_win_id;
          r_rsp_valid <= 1'b1;
          r_grant     <= '0;
          r_timer     <= '0;
        end
        RESP: begin
          // Ack on the boundary cycle wins over the timeout.
          if (rsp_ack) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
          end else if (w_timer_done) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            if (r_timeout_cnt != 8'hFF) r_timeout_cnt <= r_timeout_cnt + 8'd1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign busy        = (r_state != IDLE);
  assign timeout_cnt = r_timeout_cnt;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: reset, arithmetic, round-robin order,
// ack timeout, mid-transaction reset, stray ack and operand capture timing.
module tb_adder_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 3;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_flat;
  logic [NUM_REQ*WIDTH-1:0] b_flat;
  logic [NUM_REQ-1:0]       cin;
  logic [NUM_REQ-1:0]       grant;
  logic                     rsp_valid;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         sum;
  logic                     cout;
  logic                     rsp_ack;
  logic                     busy;
  logic [7:0]               timeout_cnt;
  logic [1:0]               o_dbg_state;
  logic [IDW-1:0]           o_dbg_ptr;

  int n_checks;
  int n_fail;

  adder_share_ctrl #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ACK_TIMEOUT(4), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .cin(cin), .grant(grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .sum(sum), .cout(cout), .rsp_ack(rsp_ack), .busy(busy),
    .timeout_cnt(timeout_cnt), .o_dbg_state(o_dbg_state), .o_dbg_ptr(o_dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c);
    a_flat[i*WIDTH +: WIDTH] = a;
    b_flat[i*WIDTH +: WIDTH] = b;
    cin[i] = c;
  endtask

  logic [3:0] grant_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [2:0] fair_sum [4] = '{3'd1, 3'd3, 3'd5, 3'd7};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req      = '0;
    a_flat   = '0;
    b_flat   = '0;
    cin      = '0;
    rsp_ack  = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst_grant", 32'(grant), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tocnt", 32'(timeout_cnt), 0);
    check("rst_ptr", 32'(o_dbg_ptr), 0);

    // Single request: 3+2+1 = 6
    set_op(0, 3'd3, 3'd2, 1'b1);
    req = 4'b0001;
    step();
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_valid_early", 32'(rsp_valid), 0);
    check("t1_busy", 32'(busy), 1);
    req = '0;
    step();
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_grant_off", 32'(grant), 0);
    check("t1_sum", 32'(sum), 6);
    check("t1_cout", 32'(cout), 0);
    check("t1_id", 32'(rsp_id), 0);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    check("t1_valid_off", 32'(rsp_valid), 0);
    check("t1_busy_off", 32'(busy), 0);

    // Overflow: 7+7+1 = 15 -> sum 7, cout 1
    set_op(2, 3'd7, 3'd7, 1'b1);
    req = 4'b0100;
    step();
    check("ov_grant", 32'(grant), 32'b0100);
    req = '0;
    step();
    check("ov_sum", 32'(sum), 7);
    check("ov_cout", 32'(cout), 1);
    check("ov_id", 32'(rsp_id), 2);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;

    // Fairness from ptr=0: all requesting, immediate ack
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 3'(i), 3'(i + 1), 1'b0);
    req     = 4'b1111;
    rsp_ack = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step();
      check($sformatf("fair_grant%0d", t), 32'(grant), 32'(grant_exp[t]));
      step();
      check($sformatf("fair_valid%0d", t), 32'(rsp_valid), 1);
      check($sformatf("fair_id%0d", t), 32'(rsp_id), 32'(t % 4));
      check($sformatf("fair_sum%0d", t), 32'(sum), 32'(fair_sum[t % 4]));
      step();
      check($sformatf("fair_done%0d", t), 32'(busy), 0);
    end
    req     = '0;
    rsp_ack = 1'b0;

    // Timeout: four valid cycles then drop, ptr moves on to requester 1
    req = 4'b0011;
    step();
    check("to_grant0", 32'(grant), 32'b0001);
    step();
    check("to_valid_c1", 32'(rsp_valid), 1);
    for (int c = 2; c <= 4; c++) begin
      step();
      check($sformatf("to_valid_c%0d", c), 32'(rsp_valid), 1);
    end
    step();
    check("to_dropped", 32'(rsp_valid), 0);
    check("to_cnt1", 32'(timeout_cnt), 1);
    check("to_busy", 32'(busy), 0);
    check("to_ptr", 32'(o_dbg_ptr), 1);
    step();
    check("to_next_grant", 32'(grant), 32'b0010);
    req = '0;
    step();
    check("to_id1", 32'(rsp_id), 1);
    step();
    step();
    step();
    check("ack4_valid", 32'(rsp_valid), 1);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    check("ack4_valid_off", 32'(rsp_valid), 0);
    check("ack4_cnt", 32'(timeout_cnt), 1);
    check("ack4_ptr", 32'(o_dbg_ptr), 2);

    // Reset during EXEC
    req = 4'b0001;
    step();
    check("rx_grant", 32'(grant), 32'b0001);
    req   = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rx_valid", 32'(rsp_valid), 0);
    check("rx_grant0", 32'(grant), 0);
    check("rx_busy", 32'(busy), 0);
    check("rx_ptr", 32'(o_dbg_ptr), 0);
    check("rx_cnt", 32'(timeout_cnt), 0);

    // Reset during RESP
    req = 4'b0010;
    step();
    req = '0;
    step();
    check("rr_valid_pre", 32'(rsp_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_valid", 32'(rsp_valid), 0);
    check("rr_grant", 32'(grant), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_ptr", 32'(o_dbg_ptr), 0);
    check("rr_cnt", 32'(timeout_cnt), 0);

    // Served normally afterwards: 5+1+0 = 6 on requester 3
    set_op(3, 3'd5, 3'd1, 1'b0);
    req = 4'b1000;
    step();
    check("post_grant", 32'(grant), 32'b1000);
    req = '0;
    step();
    check("post_id", 32'(rsp_id), 3);
    check("post_sum", 32'(sum), 6);
    check("post_cout", 32'(cout), 0);
    rsp_ack = 1'b1;
    step();
    check("post_valid_off", 32'(rsp_valid), 0);

    // Stray ack in IDLE (rsp_ack still high)
    step();
    check("stray_state", 32'(o_dbg_state), 0);
    check("stray_valid", 32'(rsp_valid), 0);
    check("stray_ptr", 32'(o_dbg_ptr), 0);

    // Operands change during EXEC, stray ack during EXEC: 1+2+0 = 3 expected
    rsp_ack = 1'b0;
    set_op(1, 3'd1, 3'd2, 1'b0);
    req = 4'b0010;
    step();
    check("hold_grant", 32'(grant), 32'b0010);
    set_op(1, 3'd7, 3'd7, 1'b1);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    req     = '0;
    check("hold_sum", 32'(sum), 3);
    check("hold_cout", 32'(cout), 0);
    check("hold_valid", 32'(rsp_valid), 1);
    step();
    check("hold_valid_kept", 32'(rsp_valid), 1);
    rsp_ack = 1'b1;
    step();
    rsp_ack = 1'b0;
    check("hold_valid_off", 32'(rsp_valid), 0);
    check("hold_cnt", 32'(timeout_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin controller that time-shares one WIDTH-bit ripple-carry adder among NUM_REQ requesters. Each requester presents operands and a carry-in and raises a request. The block grants one winner, latches its operands and registers the sum and carry-out. It then holds the result with a valid/ack handshake and a bounded acknowledge timeout. It sits between the tile's input decode and the shared adder datapath, and owns the adder instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- WIDTH, 3: operand/sum width in bits
- ACK_TIMEOUT, 1000: max cycles rsp_valid may stay unacknowledged (>=2)
- IDW, $clog2(NUM_REQ): width of requester index
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; all state cleared on the edge it is sampled high
- req  in  NUM_REQ  per-requester request level
- a_flat  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- b_flat  in  NUM_REQ*WIDTH  operand B, same packing
- cin  in  NUM_REQ  per-requester carry-in
- grant  out  NUM_REQ  one-hot, one-cycle pulse: operands of that requester were latched
- rsp_valid  out  1  result available
- rsp_id  out  IDW  index of requester owning the result
- sum  out  WIDTH  registered A+B+Cin, low WIDTH bits
- cout  out  1  registered carry-out
- rsp_ack  in  1  consumer accepts result; only meaningful while rsp_valid=1
- busy  out  1  high whenever state != IDLE
- timeout_cnt  out  8  saturating count of dropped (timed-out) results

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, req==0: remain.
- IDLE, req!=0: the winner is the first set req bit searching from ptr upward, wrapping modulo NUM_REQ.
  - On the edge: latch the winner's A, B, cin and index.
  - grant <= onehot(winner); state <= EXEC.
- EXEC: on the edge:
  - sum/cout <= latched A + B + cin.
  - rsp_id <= winner; rsp_valid <= 1; grant <= 0; timer <= 0; state <= RESP.
- RESP, rsp_ack=1: on the edge, rsp_valid <= 0, ptr <= (winner+1) mod NUM_REQ, state <= IDLE.
- RESP, rsp_ack=0: timer increments.
  - When timer == ACK_TIMEOUT-1 with no ack, the result is dropped: rsp_valid <= 0, ptr advances as for ack, state <= IDLE.
  - timeout_cnt increments, saturating at 255.
- rsp_ack while rsp_valid=0 is ignored. An ack in the same cycle as the timeout boundary counts as an ack, not a timeout.
- Arithmetic: the full sum is WIDTH+1 bits. sum = bits [WIDTH-1:0]; cout = bit WIDTH. No overflow flag.
- Operand inputs are don't-care except in the IDLE cycle where the grant decision is made. Requesters hold operands with req until they see grant.
- A req still high after its grant competes again at the next IDLE, at lowest priority due to the ptr rotation.
- sum, cout and rsp_id hold their last values after rsp_valid falls; they are only meaningful while rsp_valid=1.

## Timing
- Reset values:
  - state=IDLE, ptr=0, grant=0, rsp_valid=0, rsp_id=0, sum=0, cout=0, busy=0, timer=0, timeout_cnt=0.
- Reset mid-transaction aborts it and drops the result with no timeout count; the controller is in IDLE the cycle after.
- Latency:
  - req sampled at edge k -> grant high during cycle k+1.
  - rsp_valid rises after edge k+1 (2 edges from request).
- Throughput: minimum 3 cycles per transaction (IDLE, EXEC, RESP with same-cycle ack). No request is sampled while busy=1.
- Maximum RESP residency: ACK_TIMEOUT cycles.
- All outputs are registered except busy, which decodes state directly.

## Test plan
- Reset then single request:
  - Stimulus: req=0001, A0=3, B0=2, cin0=1; ack on first rsp_valid cycle.
  - Required: grant=0001 for one cycle; rsp_valid 2 edges after req; sum=6, cout=0, rsp_id=0; busy drops after the ack edge.
- Overflow:
  - Stimulus: A=7, B=7, cin=1 on requester 2.
  - Required: sum=7, cout=1, rsp_id=2.
- Fairness:
  - Stimulus: req=1111 held, immediate acks, 8 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3, each transaction 3 cycles apart.
- Timeout:
  - Stimulus: ACK_TIMEOUT=4, no ack.
  - Required: rsp_valid high exactly 4 cycles, timeout_cnt 0->1, ptr advanced, next winner is the following requester.
  - Ack on the 4th cycle: no increment.
- Reset mid-op:
  - Stimulus: assert reset during EXEC, then during RESP.
  - Required: next cycle rsp_valid=0, grant=0, busy=0, ptr=0, timeout_cnt=0; a subsequent req=1000 is served normally.
- Stray ack and operand hold:
  - Stimulus: rsp_ack=1 while IDLE; change operands during EXEC.
  - Required: no state change on the stray ack; the result reflects the operands present in the grant-decision cycle.
